terrain_probe_sequencer: RTL and testbench
==========================================

Name: terrain_probe_sequencer

Overview:
- Time-multiplexes one 2-bit terrain map BRAM read port.
- Serves two clients:
  - The ball's five collision probes: center, x+1, x-1, y+1, y-1.
  - A renderer tile-lookup requester.
- Replaces per-probe BRAM copies. One probe burst runs per frame; the five results are presented atomically to the gameplay FSM.

Parameters:
- WIDTH, 160, map width in tiles; address = x + WIDTH*y.
- HEIGHT, 90, map height in tiles.
- READ_LATENCY, 2, cycles from bram_addr to valid bram_data (HIGH_PERFORMANCE BRAM).
- WALL_CODE, 2'd1, terrain code reported for off-map probes.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-low reset.
- probe_start  input  1  one-cycle pulse (new_frame); starts a probe burst.
- ball_x  input  16  8.8 fixed-point ball x; only [15:8] used.
- ball_y  input  16  8.8 fixed-point ball y; only [15:8] used.
- render_req  input  1  renderer read request (level).
- render_addr  input  16  renderer tile address; held until render_ack.
- render_ack  output  1  renderer address issued this cycle.
- render_valid  output  1  render_data valid (one-cycle pulse).
- render_data  output  2  terrain code for the acked renderer address.
- bram_addr  output  16  BRAM address.
- bram_data  input  2  BRAM read data.
- terrain_c, terrain_xp, terrain_xm, terrain_yp, terrain_ym  output  2 each  latest probe results.
- probe_valid  output  1  one-cycle pulse; probe outputs were just updated.
- busy  output  1  high from the cycle after probe_start until probe_valid (inclusive).
- missed_count  output  8  saturating count of probe_start pulses ignored while busy.

Behaviour:
- Reset (async, rst_in=0):
  - State = IDLE.
  - terrain_* = 2'd2 (grass, never hole).
  - probe_valid, busy, render_ack, render_valid = 0.
  - render_data, bram_addr, missed_count = 0.
  - Tag pipeline cleared; in-flight BRAM returns are discarded.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - probe_start latches xi=ball_x[15:8] and yi=ball_y[15:8].
  - Next state is ISSUE with slot index 0.
- ISSUE:
  - One slot per cycle, in order: center, x+, x-, y+, y-. Exactly 5 cycles.
  - Each slot drives bram_addr and pushes a tag {valid, src=probe, idx, forced_wall} into a READ_LATENCY-deep shift register.
- Off-map rule:
  - forced_wall is set when the probed tile is off-map: x<0, x>=WIDTH, y<0 or y>=HEIGHT. This includes xi=0 for x-, xi=WIDTH-1 for x+, yi=0 for y-, yi=HEIGHT-1 for y+.
  - If the center tile is off-map, all 5 slots are forced_wall.
  - A forced slot still occupies its cycle (fixed latency). Its result is WALL_CODE; bram_data is ignored.
- Address arithmetic: 16-bit unsigned. Maximum in-map address is WIDTH*HEIGHT-1 = 14399; no overflow.
- DRAIN: wait until the tag pipeline holds no probe tags.
- Result capture: results land in shadow registers as tags retire.
- DONE:
  - Copy the shadows to terrain_* in a single cycle and pulse probe_valid for one cycle.
  - Return to IDLE.
- Probe timing: probe_start sampled high in cycle 0 -> bram_addr slots in cycles 1..5 -> probe_valid high in cycle 6+READ_LATENCY (cycle 8 at the default).
- Renderer arbitration:
  - A render_req slot is granted (render_ack=1, bram_addr=render_addr) in any cycle not in ISSUE.
  - This includes the IDLE cycle in which probe_start is sampled; probe slots start the following cycle.
  - Probe slots always win; render_ack=0 throughout ISSUE.
  - An acked request returns render_valid=1 with render_data exactly READ_LATENCY cycles after its ack.
  - Back-to-back acks are allowed: one per cycle, in order.
- probe_start handling outside IDLE:
  - Ignored; missed_count increments, saturating at 255.
  - probe_start in the same cycle as probe_valid also counts as missed.
- Between probes, terrain_* hold their values; no output changes without probe_valid.
- bram_addr holds its last value when no slot is issued.
- Reset mid-burst: immediate return to the reset values. A partial burst never updates terrain_* and never pulses probe_valid.

Test Plan:
- Ball (10.0,10.0), map tiles (10,10)=2, (11,10)=1, others 2; probe_start at cycle 0 -> bram_addr 1610,1611,1609,1770,1450 on cycles 1..5; probe_valid at cycle 8 with c=2, xp=1, xm=2, yp=2, ym=2.
- Ball (0.5,0.0) -> xm=1 and ym=1 (forced, no dependence on bram_data); probe_valid still at cycle 8.
- Ball (159.0,89.0) -> xp=1 and yp=1 forced; bram_addr for center = 14399.
- render_req held high with addr 100 from cycle 0, probe_start at cycle 0 -> render_ack at cycles 0, 6, 7..., 0 in cycles 1..5; render_valid 2 cycles after each ack with data of tile 100.
- probe_start pulses at cycles 0 and 3 -> second pulse ignored; missed_count=1; exactly one probe_valid (cycle 8).
- rst_in low at cycle 4 of a burst, released at cycle 6 -> no probe_valid; terrain_*=2; busy=0; a new probe_start at cycle 10 completes normally at cycle 18.

Source files
------------

// File: rtl/terrain_probe_sequencer.sv
// terrain_probe_sequencer
// Shares one terrain-map BRAM read port between the ball's five collision
// probes (center, x+1, x-1, y+1, y-1) and the renderer's tile lookups.
// A probe burst issues five reads on consecutive cycles, collects the
// returns in shadow registers and publishes all five results in one cycle.
// Renderer reads are granted in every cycle that is not a probe slot.
//
// Cycle numbering used throughout: a probe_start seen at clock edge 0
// drives the five slot addresses at edges 1..5. Data for an address
// driven at edge k is sampled at edge k+READ_LATENCY. probe_valid is
// raised at edge 6+READ_LATENCY.

module terrain_probe_sequencer #(
    parameter int         WIDTH        = 160,
    parameter int         HEIGHT       = 90,
    parameter int         READ_LATENCY = 2,
    parameter logic [1:0] WALL_CODE    = 2'd1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        probe_start,
    input  logic [15:0] ball_x,
    input  logic [15:0] ball_y,
    input  logic        render_req,
    input  logic [15:0] render_addr,
    output logic        render_ack,
    output logic        render_valid,
    output logic [1:0]  render_data,
    output logic [15:0] bram_addr,
    input  logic [1:0]  bram_data,
    output logic [1:0]  terrain_c,
    output logic [1:0]  terrain_xp,
    output logic [1:0]  terrain_xm,
    output logic [1:0]  terrain_yp,
    output logic [1:0]  terrain_ym,
    output logic        probe_valid,
    output logic        busy,
    output logic [7:0]  missed_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One entry per outstanding BRAM read; idx selects the probe slot.
    typedef struct packed {
        logic       valid;
        logic       probe;
        logic [2:0] idx;
        logic       forced;
    } tag_t;

    // Grass: the safe value shown before any probe has completed.
    localparam logic [1:0]  GRASS_CODE = 2'd2;
    localparam logic [8:0]  WIDTH_9    = 9'(WIDTH);
    localparam logic [8:0]  HEIGHT_9   = 9'(HEIGHT);
    localparam logic [15:0] WIDTH_16   = 16'(WIDTH);

    state_t      state_r;
    logic [2:0]  slot_r;
    logic [7:0]  xi_r;
    logic [7:0]  yi_r;
    tag_t        tag_r [READ_LATENCY];
    tag_t        retire_s;
    logic [1:0]  shadow_r [5];

    logic [8:0]  cx_s;
    logic [8:0]  cy_s;
    logic [8:0]  nx_s;
    logic [8:0]  ny_s;
    logic        issue_forced_s;
    logic [15:0] issue_addr_s;
    logic        pending_probe_s;

    // Only the integer tile part of the ball position is used.
    logic        frac_unused_s;
    assign frac_unused_s = ^{ball_x[7:0], ball_y[7:0]};

    assign retire_s = tag_r[READ_LATENCY-1];

    // Neighbour tile, off-map detection and address of the current probe slot
    always_comb begin
        cx_s = {1'b0, xi_r};
        cy_s = {1'b0, yi_r};
        case (slot_r)
            3'd1: begin
                nx_s = cx_s + 9'd1;
                ny_s = cy_s;
            end
            3'd2: begin
                nx_s = cx_s - 9'd1;   // x=0 wraps to 511, which is off-map
                ny_s = cy_s;
            end
            3'd3: begin
                nx_s = cx_s;
                ny_s = cy_s + 9'd1;
            end
            3'd4: begin
                nx_s = cx_s;
                ny_s = cy_s - 9'd1;   // y=0 wraps to 511, which is off-map
            end
            default: begin
                nx_s = cx_s;
                ny_s = cy_s;
            end
        endcase
        // An off-map center forces every slot, not only its own
        issue_forced_s = (cx_s >= WIDTH_9) || (cy_s >= HEIGHT_9) ||
                         (nx_s >= WIDTH_9) || (ny_s >= HEIGHT_9);
        issue_addr_s   = {7'd0, nx_s} + ({7'd0, ny_s} * WIDTH_16);
    end

    // True while a probe read other than the one retiring now is still in flight
    always_comb begin
        pending_probe_s = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            pending_probe_s = pending_probe_s | (tag_r[i].valid & tag_r[i].probe);
        end
    end

    // Port arbitration: probe slots own ISSUE, renderer gets every other cycle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bram_addr  <= 16'd0;
            render_ack <= 1'b0;
        end else if (state_r == ISSUE) begin
            bram_addr  <= issue_addr_s;
            render_ack <= 1'b0;
        end else if (render_req) begin
            bram_addr  <= render_addr;
            render_ack <= 1'b1;
        end else begin
            render_ack <= 1'b0;
        end
    end

    // Tag pipeline that follows each read through the BRAM latency
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            if (state_r == ISSUE) begin
                tag_r[0] <= '{valid: 1'b1, probe: 1'b1, idx: slot_r, forced: issue_forced_s};
            end else if (render_req) begin
                tag_r[0] <= '{valid: 1'b1, probe: 1'b0, idx: 3'd0, forced: 1'b0};
            end else begin
                tag_r[0] <= '0;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Route retiring BRAM data to the renderer or to a probe shadow register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            render_valid <= 1'b0;
            render_data  <= 2'd0;
            for (int i = 0; i < 5; i++) begin
                shadow_r[i] <= GRASS_CODE;
            end
        end else begin
            render_valid <= 1'b0;
            if (retire_s.valid && !retire_s.probe) begin
                render_valid <= 1'b1;
                render_data  <= bram_data;
            end else if (retire_s.valid && retire_s.probe) begin
                shadow_r[retire_s.idx] <= retire_s.forced ? WALL_CODE : bram_data;
            end else begin
                render_data <= render_data;
            end
        end
    end

    // Burst sequencer: latch position, issue slots, drain, publish results
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= IDLE;
            slot_r       <= 3'd0;
            xi_r         <= 8'd0;
            yi_r         <= 8'd0;
            terrain_c    <= GRASS_CODE;
            terrain_xp   <= GRASS_CODE;
            terrain_xm   <= GRASS_CODE;
            terrain_yp   <= GRASS_CODE;
            terrain_ym   <= GRASS_CODE;
            probe_valid  <= 1'b0;
            busy         <= 1'b0;
            missed_count <= 8'd0;
        end else begin
            probe_valid <= 1'b0;
            busy        <= (state_r != IDLE);
            if (probe_start && (state_r != IDLE) && (missed_count != 8'hFF)) begin
                missed_count <= missed_count + 8'd1;
            end
            case (state_r)
                IDLE: begin
                    if (probe_start) begin
                        xi_r    <= ball_x[15:8];
                        yi_r    <= ball_y[15:8];
                        slot_r  <= 3'd0;
                        state_r <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (slot_r == 3'd4) begin
                        slot_r  <= 3'd0;
                        state_r <= DRAIN;
                    end else begin
                        slot_r <= slot_r + 3'd1;
                    end
                end
                DRAIN: begin
                    if (!pending_probe_s) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    terrain_c   <= shadow_r[0];
                    terrain_xp  <= shadow_r[1];
                    terrain_xm  <= shadow_r[2];
                    terrain_yp  <= shadow_r[3];
                    terrain_ym  <= shadow_r[4];
                    probe_valid <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_terrain_probe_sequencer.sv
// Self-checking bench for terrain_probe_sequencer.
// A behavioural BRAM stand-in serves a terrain array; the reference model
// derives probe results and addresses from tile coordinates with plain
// integer arithmetic. Cycle k means "just after clock edge k", where the
// probe_start pulse is sampled at edge 0.
`timescale 1ns/1ps

module tb_terrain_probe_sequencer;

    localparam int         W    = 160;
    localparam int         H    = 90;
    localparam int         NT   = W * H;
    localparam logic [1:0] WALL = 2'd1;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        probe_start = 1'b0;
    logic [15:0] ball_x = 16'd0;
    logic [15:0] ball_y = 16'd0;
    logic        render_req = 1'b0;
    logic [15:0] render_addr = 16'd0;
    logic        render_ack;
    logic        render_valid;
    logic [1:0]  render_data;
    logic [15:0] bram_addr;
    logic [1:0]  bram_data;
    logic [1:0]  terrain_c, terrain_xp, terrain_xm, terrain_yp, terrain_ym;
    logic        probe_valid;
    logic        busy;
    logic [7:0]  missed_count;

    terrain_probe_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in), .probe_start(probe_start),
        .ball_x(ball_x), .ball_y(ball_y),
        .render_req(render_req), .render_addr(render_addr),
        .render_ack(render_ack), .render_valid(render_valid), .render_data(render_data),
        .bram_addr(bram_addr), .bram_data(bram_data),
        .terrain_c(terrain_c), .terrain_xp(terrain_xp), .terrain_xm(terrain_xm),
        .terrain_yp(terrain_yp), .terrain_ym(terrain_ym),
        .probe_valid(probe_valid), .busy(busy), .missed_count(missed_count)
    );

    always #5 clk_in = ~clk_in;

    // Terrain contents and BRAM stand-in: address at edge k, data sampled at edge k+2.
    // Addresses past the map read as hole (0) so an unforced off-map slot shows up.
    logic [1:0] mem [NT];
    logic [1:0] bram_q;
    always @(posedge clk_in) bram_q <= (bram_addr < 16'(NT)) ? mem[bram_addr] : 2'd0;
    assign bram_data = bram_q;

    int edge_n = 0;
    always @(posedge clk_in) edge_n <= edge_n + 1;

    int tests = 0;
    int fails = 0;
    int probe_edge = -100;
    bit render_on = 1'b0;
    bit render_fixed = 1'b0;
    logic [15:0] got_addr [5];
    logic [9:0]  got_res;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: tile address of a slot, or -1 when the slot is off-map
    function automatic int model_addr(input int x, input int y, input int slot);
        int nx, ny;
        nx = x + ((slot == 1) ? 1 : (slot == 2) ? -1 : 0);
        ny = y + ((slot == 3) ? 1 : (slot == 4) ? -1 : 0);
        if (x >= W || y >= H || nx < 0 || nx >= W || ny < 0 || ny >= H) return -1;
        return nx + W * ny;
    endfunction

    function automatic logic [1:0] model_res(input int x, input int y, input int slot);
        int a;
        a = model_addr(x, y, slot);
        if (a < 0) return WALL;
        return mem[a];
    endfunction

    function automatic logic [9:0] terr();
        return {terrain_c, terrain_xp, terrain_xm, terrain_yp, terrain_ym};
    endfunction

    // One complete probe burst, checked cycle by cycle against the model
    task automatic run_probe(input logic [15:0] bx, input logic [15:0] by);
        int x, y, a, pv_at, pvs;
        logic [9:0] exp_t, pre;
        x = int'(bx[15:8]);
        y = int'(by[15:8]);
        for (int s = 0; s < 5; s++) exp_t[9-2*s -: 2] = model_res(x, y, s);
        @(negedge clk_in);
        pre = terr();
        ball_x = bx; ball_y = by; probe_start = 1'b1; probe_edge = edge_n;
        @(negedge clk_in);
        probe_start = 1'b0;
        pv_at = -1; pvs = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            if (k <= 5) begin
                got_addr[k-1] = bram_addr;
                a = model_addr(x, y, k - 1);
                if (a >= 0) check($sformatf("slot%0d_addr", k - 1), int'(bram_addr), a);
                check("ack_in_issue", int'(render_ack), 0);
            end
            if (k == 7) check("hold_before_valid", int'(terr()), int'(pre));
            check($sformatf("busy_c%0d", k), int'(busy), int'(k <= 8));
            if (probe_valid) begin
                pvs++;
                if (pv_at < 0) pv_at = k;
            end
        end
        got_res = terr();
        check("probe_valid_count", pvs, 1);
        check("probe_valid_cycle", pv_at, 8);
        for (int s = 0; s < 5; s++)
            check($sformatf("res_slot%0d", s), int'(got_res[9-2*s -: 2]), int'(exp_t[9-2*s -: 2]));
    endtask

    // Probe at cycle 0 plus a second probe_start at cycle 'second'
    task automatic run_pair(input int second, input int exp_missed);
        int pvs, pv_at;
        @(negedge clk_in);
        ball_x = 16'h0A00; ball_y = 16'h0A00; probe_start = 1'b1;
        pvs = 0; pv_at = -1;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk_in);
            probe_start = (k + 1 == second);
            if (probe_valid) begin
                pvs++;
                if (pv_at < 0) pv_at = k;
            end
        end
        check("pair_valid_count", pvs, 1);
        check("pair_valid_cycle", pv_at, 8);
        check("pair_missed", int'(missed_count), exp_missed);
    endtask

    // Renderer agent: issues requests and scores ack timing and returned data
    initial begin : render_agent
        bit a1v, a2v, exp_ack, in_issue;
        logic [1:0] a1d, a2d;
        int last;
        a1v = 1'b0; a2v = 1'b0; a1d = 2'd0; a2d = 2'd0;
        forever begin
            @(negedge clk_in);
            if (render_on) begin
                last = edge_n - 1;
                check("render_valid", int'(render_valid), int'(a2v));
                if (a2v) check("render_data", int'(render_data), int'(a2d));
                in_issue = (last >= probe_edge + 1) && (last <= probe_edge + 5);
                exp_ack = render_req && !in_issue;
                check("render_ack", int'(render_ack), int'(exp_ack));
                a2v = a1v; a2d = a1d;
                a1v = exp_ack; a1d = mem[render_addr];
                if (exp_ack || !render_req) begin
                    if (render_fixed) begin
                        render_req = 1'b1; render_addr = 16'd100;
                    end else begin
                        render_req = 1'($urandom_range(0, 1));
                        render_addr = 16'($urandom_range(0, NT - 1));
                    end
                end
            end else begin
                a1v = 1'b0; a2v = 1'b0; render_req = 1'b0;
            end
        end
    end

    typedef struct {
        logic [15:0] bx;
        logic [15:0] by;
        int          caddr;   // -1: center address not checked (center off-map)
        logic [9:0]  res;     // {c, xp, xm, yp, ym}
    } vec_t;
    vec_t vecs [8];

    initial begin : bounded_run
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        vecs[0] = '{16'h0A00, 16'h0A00, 1610,  {2'd2, 2'd1, 2'd2, 2'd2, 2'd2}};
        vecs[1] = '{16'h0080, 16'h0000, 0,     {2'd2, 2'd2, 2'd1, 2'd2, 2'd1}};
        vecs[2] = '{16'h9F00, 16'h5900, 14399, {2'd2, 2'd1, 2'd2, 2'd1, 2'd2}};
        vecs[3] = '{16'hC800, 16'h0A00, -1,    {2'd1, 2'd1, 2'd1, 2'd1, 2'd1}};
        vecs[4] = '{16'hA000, 16'h0000, -1,    {2'd1, 2'd1, 2'd1, 2'd1, 2'd1}};
        vecs[5] = '{16'h0500, 16'h5A00, -1,    {2'd1, 2'd1, 2'd1, 2'd1, 2'd1}};
        vecs[6] = '{16'h14C0, 16'h1E40, 4820,  {2'd3, 2'd0, 2'd1, 2'd1, 2'd0}};
        vecs[7] = '{16'h0000, 16'h5900, 14240, {2'd2, 2'd2, 2'd1, 2'd1, 2'd2}};
        for (int i = 0; i < NT; i++) mem[i] = 2'd2;
        mem[11 + W * 10] = 2'd1;
        mem[20 + W * 30] = 2'd3;
        mem[21 + W * 30] = 2'd0;
        mem[19 + W * 30] = 2'd1;
        mem[20 + W * 31] = 2'd1;
        mem[20 + W * 29] = 2'd0;

        // Reset values
        repeat (3) @(negedge clk_in);
        check("rst_terrain", int'(terr()), int'({2'd2, 2'd2, 2'd2, 2'd2, 2'd2}));
        check("rst_probe_valid", int'(probe_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_render_ack", int'(render_ack), 0);
        check("rst_render_valid", int'(render_valid), 0);
        check("rst_render_data", int'(render_data), 0);
        check("rst_bram_addr", int'(bram_addr), 0);
        check("rst_missed", int'(missed_count), 0);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_probe(vecs[i].bx, vecs[i].by);
            if (vecs[i].caddr >= 0) check($sformatf("tbl%0d_caddr", i), int'(got_addr[0]), vecs[i].caddr);
            check($sformatf("tbl%0d_res", i), int'(got_res), int'(vecs[i].res));
        end

        // Renderer held on tile 100 while a probe runs
        render_on = 1'b1; render_fixed = 1'b1;
        run_probe(16'h0A00, 16'h0A00);
        render_on = 1'b0; render_fixed = 1'b0;
        repeat (4) @(negedge clk_in);

        // probe_start while busy and on the probe_valid cycle
        run_pair(3, 1);
        run_pair(8, 2);

        // Saturation of missed_count with probe_start held high
        @(negedge clk_in);
        ball_x = 16'h0A00; ball_y = 16'h0A00; probe_start = 1'b1;
        repeat (320) @(negedge clk_in);
        probe_start = 1'b0;
        repeat (12) @(negedge clk_in);
        check("missed_saturated", int'(missed_count), 255);
        check("terrain_after_sat", int'(terr()), int'({2'd2, 2'd1, 2'd2, 2'd2, 2'd2}));

        // Reset in the middle of a burst (low in cycles 4..5)
        @(negedge clk_in);
        ball_x = 16'h0A00; ball_y = 16'h0A00; probe_start = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk_in);
            probe_start = 1'b0;
            if (k == 3) begin
                rst_in = 1'b0;
                #1;
                check("midrst_terrain", int'(terr()), int'({2'd2, 2'd2, 2'd2, 2'd2, 2'd2}));
                check("midrst_busy", int'(busy), 0);
                check("midrst_missed", int'(missed_count), 0);
            end
            if (k == 5) rst_in = 1'b1;
            if (k >= 4) begin
                check($sformatf("midrst_pv_c%0d", k), int'(probe_valid), 0);
                check($sformatf("midrst_busy_c%0d", k), int'(busy), 0);
                check($sformatf("midrst_rv_c%0d", k), int'(render_valid), 0);
                check($sformatf("midrst_terr_c%0d", k), int'(terr()), int'({2'd2, 2'd2, 2'd2, 2'd2, 2'd2}));
            end
        end
        run_probe(16'h0A00, 16'h0A00);

        // Randomized probes over a random map with random renderer traffic
        for (int i = 0; i < NT; i++) mem[i] = 2'($urandom_range(0, 3));
        render_on = 1'b1;
        for (int n = 0; n < 30; n++) begin
            run_probe(16'({$urandom_range(0, 165), 8'($urandom_range(0, 255))}),
                      16'({$urandom_range(0, 95), 8'($urandom_range(0, 255))}));
        end
        render_on = 1'b0;
        repeat (4) @(negedge clk_in);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
